// File: rtl/fifo_wr_arb_pkg.sv
// rtl/fifo_wr_arb_pkg.sv - shared state type and index helper for fifo_wr_arbiter
package fifo_wr_arb_pkg;

  localparam int MAX_PRODUCERS = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  function automatic logic [3:0] onehot2idx(input logic [MAX_PRODUCERS-1:0] onehot);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_PRODUCERS; i++) begin
      if (onehot[i]) idx = idx | 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// rtl/fifo_wr_arbiter_rr_picker.sv - combinational round-robin pick of the first request at or after ptr
module rr_picker #(
  parameter int N = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic          found
);

  logic [2*N-1:0] req_dbl;
  logic [2*N-1:0] pick_dbl;
  logic [N-1:0]   req_rot;
  logic [N-1:0]   pick_rot;

  // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    req_dbl  = {req, req} >> ptr;
    req_rot  = N'(req_dbl);
    pick_rot = req_rot & (~req_rot + N'(1));
    pick_dbl = {pick_rot, pick_rot} << ptr;
    pick     = N'(pick_dbl >> N);
    found    = |req;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter sharing one FIFO write port among N producers
// Optional almost-full admission gate: FIFO_WR_ARB_AFULL_EN
module fifo_wr_arbiter
  import fifo_wr_arb_pkg::*;
#(
  parameter int N          = 4,
  parameter int DWIDTH     = 8,
  parameter int AWIDTH_EXP = 3,
  parameter int BURST_LEN  = 4
`ifdef FIFO_WR_ARB_AFULL_EN
  ,
  parameter int AFULL_LEVEL = 2**AWIDTH_EXP - 2
`endif
) (
  input  logic                  clk_i,
  input  logic                  srst_i,
  input  logic [N-1:0]          req_valid_i,
  input  logic [N*DWIDTH-1:0]   req_data_i,
  output logic [N-1:0]          req_ready_o,
  output logic [DWIDTH-1:0]     fifo_data_o,
  output logic                  fifo_wrreq_o,
  input  logic                  fifo_full_i,
  input  logic [AWIDTH_EXP-1:0] fifo_usedw_i,
  output logic [N-1:0]          grant_o,
  output logic                  busy_o
);

  localparam int PW = $clog2(N);
  localparam int CW = $clog2(BURST_LEN + 1);

  arb_state_t    state;
  arb_state_t    next_state;
  logic [N-1:0]  grant_q;
  logic [PW-1:0] rr_ptr;
  logic [CW-1:0] burst_cnt;

  logic [N-1:0]  pick;
  logic          found;
  logic [PW-1:0] g_idx;
  logic [PW-1:0] rr_next;
  logic          g_valid;
  logic          xfer;
  logic          burst_done;
  logic          release_grant;
  logic          start_grant;
  logic          afull;

  rr_picker #(.N(N)) u_picker (
    .req   (req_valid_i),
    .ptr   (rr_ptr),
    .pick  (pick),
    .found (found)
  );

`ifdef FIFO_WR_ARB_AFULL_EN
  localparam int FW = AWIDTH_EXP + 1;
  logic [AWIDTH_EXP:0] fill;
  // usedw wraps to 0 when full, so full supplies the missing top count.
  assign fill  = fifo_full_i ? FW'(2**AWIDTH_EXP) : {1'b0, fifo_usedw_i};
  assign afull = (fill >= FW'(AFULL_LEVEL));
`else
  logic unused_usedw;
  assign unused_usedw = ^fifo_usedw_i;
  assign afull        = 1'b0;
`endif

  assign g_idx   = PW'(onehot2idx(MAX_PRODUCERS'(grant_q)));
  assign rr_next = (g_idx == PW'(N - 1)) ? '0 : g_idx + PW'(1);

  always_comb begin
    g_valid       = |(req_valid_i & grant_q);
    xfer          = (state == GRANT) && g_valid && !fifo_full_i;
    burst_done    = xfer && (burst_cnt == CW'(BURST_LEN - 1));
    // A full FIFO with valid still high is a stall; only a gap or a finished burst releases.
    release_grant = (state == GRANT) && (!g_valid || burst_done);
    start_grant   = (state == IDLE) && found && !afull;
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (start_grant)   next_state = GRANT;
      GRANT: if (release_grant) next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      grant_q   <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      if (start_grant) begin
        grant_q   <= pick;
        burst_cnt <= '0;
      end
      if (xfer) burst_cnt <= burst_cnt + CW'(1);
      if (release_grant) begin
        grant_q <= '0;
        rr_ptr  <= rr_next;
      end
    end
  end

  always_comb begin
    req_ready_o  = '0;
    fifo_wrreq_o = 1'b0;
    fifo_data_o  = '0;
    busy_o       = 1'b0;
    if (state == GRANT) begin
      busy_o       = 1'b1;
      req_ready_o  = fifo_full_i ? '0 : grant_q;
      fifo_wrreq_o = xfer;
      for (int i = 0; i < N; i++) begin
        if (grant_q[i]) fifo_data_o = fifo_data_o | req_data_i[i*DWIDTH +: DWIDTH];
      end
    end
  end

  assign grant_o = grant_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - scoreboard bench for fifo_wr_arbiter with a FIFO occupancy model
module tb_fifo_wr_arbiter;

  localparam int N  = 3;
  localparam int DW = 8;
  localparam int AW = 3;
  localparam int BL = 4;

  logic            clk = 1'b0;
  logic            srst;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic [DW-1:0]   fifo_data;
  logic            fifo_wrreq;
  logic            fifo_full;
  logic [AW-1:0]   fifo_usedw;
  logic [N-1:0]    grant;
  logic            busy;

  logic            rd_en;
  logic [AW:0]     fifo_cnt;
  logic [N-1:0]    fire;
  logic            flush;
  logic [9:0]      mon_e;

  int n_cmp = 0;
  int n_bad = 0;

  logic [9:0] exp_q[$];
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] q2[$];

  fifo_wr_arbiter #(
    .N          (N),
    .DWIDTH     (DW),
    .AWIDTH_EXP (AW),
    .BURST_LEN  (BL)
`ifdef FIFO_WR_ARB_AFULL_EN
    ,
    .AFULL_LEVEL(6)
`endif
  ) dut (
    .clk_i        (clk),
    .srst_i       (srst),
    .req_valid_i  (req_valid),
    .req_data_i   (req_data),
    .req_ready_o  (req_ready),
    .fifo_data_o  (fifo_data),
    .fifo_wrreq_o (fifo_wrreq),
    .fifo_full_i  (fifo_full),
    .fifo_usedw_i (fifo_usedw),
    .grant_o      (grant),
    .busy_o       (busy)
  );

  initial forever #5 clk = ~clk;

  // Depth-8 FIFO occupancy: registered count, usedw wraps to 0 at full.
  assign fifo_full  = (fifo_cnt == 4'd8);
  assign fifo_usedw = fifo_cnt[AW-1:0];
  always @(posedge clk) begin
    if (srst) fifo_cnt <= '0;
    else fifo_cnt <= fifo_cnt + ((fifo_wrreq && !fifo_full) ? 4'd1 : 4'd0)
                              - ((rd_en && fifo_cnt != 4'd0) ? 4'd1 : 4'd0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic src(input int p, input logic [7:0] d);
    case (p)
      0: q0.push_back(d);
      1: q1.push_back(d);
      default: q2.push_back(d);
    endcase
  endtask

  task automatic expw(input int p, input logic [7:0] d);
    exp_q.push_back({2'(p), d});
  endtask

  task automatic refresh();
    req_valid[0]    = (q0.size() != 0);
    req_valid[1]    = (q1.size() != 0);
    req_valid[2]    = (q2.size() != 0);
    req_data[7:0]   = (q0.size() != 0) ? q0[0] : 8'h00;
    req_data[15:8]  = (q1.size() != 0) ? q1[0] : 8'h00;
    req_data[23:16] = (q2.size() != 0) ? q2[0] : 8'h00;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      tick();
      k++;
    end
    chk(name, exp_q.size(), 0);
    tick(3);
  endtask

  // Producer driver: handshakes seen mid-cycle are retired after the edge.
  initial begin
    req_valid = '0;
    req_data  = '0;
    forever begin
      @(negedge clk);
      fire  = req_valid & req_ready;
      flush = srst;
      @(posedge clk);
      #1;
      if (flush) begin
        q0.delete();
        q1.delete();
        q2.delete();
      end else begin
        if (fire[0]) void'(q0.pop_front());
        if (fire[1]) void'(q1.pop_front());
        if (fire[2]) void'(q2.pop_front());
      end
      #1;
      refresh();
    end
  end

  // Write monitor: every FIFO write must match the head of the expected queue.
  always @(negedge clk) begin
    if (!srst && fifo_wrreq) begin
      chk("wr_into_full", fifo_full, 0);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got data 0x%0h grant %b, expected no write", fifo_data, grant);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_data", fifo_data, mon_e[7:0]);
        chk("wr_grant", grant, 32'(1) << mon_e[9:8]);
      end
    end
  end

  initial begin
    srst  = 1'b1;
    rd_en = 1'b0;
    tick(3);
    chk("rst_grant", grant, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_wrreq", fifo_wrreq, 0);
    chk("rst_data", fifo_data, 0);
    chk("rst_busy", busy, 0);
    srst = 1'b0;
    tick();

    // Round-robin with all producers busy and continuous reads.
    rd_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      src(0, 8'(8'hA0 + k));
      src(1, 8'(8'hB0 + k));
      src(2, 8'(8'hC0 + k));
    end
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < 3; p++)
        for (int k = 0; k < 4; k++)
          expw(p, 8'(8'hA0 + 16 * p + 4 * r + k));
    tick();
    chk("rr_grant0", grant, 3'b001);
    chk("rr_busy", busy, 1);
    tick(4);
    chk("rr_idle_gap", grant, 0);
    chk("rr_idle_busy", busy, 0);
    tick();
    chk("rr_grant1", grant, 3'b010);
    drain("rr_drain");

    // Gap release after 2 words from producer 1.
    src(1, 8'hB8);
    src(1, 8'hB9);
    expw(1, 8'hB8);
    expw(1, 8'hB9);
    tick();
    chk("gap_grant", grant, 3'b010);
    tick(2);
    chk("gap_hold", grant, 3'b010);
    tick();
    chk("gap_release", grant, 0);
    chk("gap_busy", busy, 0);
    src(0, 8'hA8);
    src(1, 8'hBA);
    for (int k = 0; k < 4; k++) src(2, 8'(8'hC8 + k));
    for (int k = 0; k < 4; k++) expw(2, 8'(8'hC8 + k));
    expw(0, 8'hA8);
    expw(1, 8'hBA);
    tick();
    chk("gap_next_ptr", grant, 3'b100);
    drain("gap_drain");

    // Full stall: no reads, producer 0 streams 10 words.
    rd_en = 1'b0;
    for (int k = 0; k < 10; k++) src(0, 8'(8'hD0 + k));
    for (int k = 0; k < 8; k++) expw(0, 8'(8'hD0 + k));
    for (int k = 0; k < 60 && !fifo_full; k++) tick();
    chk("full_reached", fifo_full, 1);
    chk("full_usedw", fifo_usedw, 0);
    chk("full_eight", exp_q.size(), 0);
    tick(3);
    chk("stall_grant", grant, 3'b001);
    chk("stall_busy", busy, 1);
    chk("stall_ready", req_ready, 0);
    expw(0, 8'hD8);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    tick(3);
    chk("one_more", exp_q.size(), 0);
    chk("refull", fifo_full, 1);
    chk("stall_ready2", req_ready, 0);
    chk("stall_grant2", grant, 3'b001);
    srst = 1'b1;
    tick();
    srst = 1'b0;
    tick();
    rd_en = 1'b1;

    // Reset mid-burst with rr_ptr moved off 0 beforehand.
    src(1, 8'h40);
    expw(1, 8'h40);
    tick();
    chk("pre_grant", grant, 3'b010);
    drain("pre_drain");
    for (int k = 0; k < 4; k++) src(2, 8'(8'h50 + k));
    expw(2, 8'h50);
    expw(2, 8'h51);
    tick();
    chk("mid_grant", grant, 3'b100);
    tick(2);
    srst = 1'b1;
    tick();
    chk("mrst_grant", grant, 0);
    chk("mrst_ready", req_ready, 0);
    chk("mrst_wrreq", fifo_wrreq, 0);
    chk("mrst_data", fifo_data, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_words", exp_q.size(), 0);
    srst = 1'b0;
    tick(2);
    src(0, 8'h60);
    src(1, 8'h70);
    src(2, 8'h80);
    expw(0, 8'h60);
    expw(1, 8'h70);
    expw(2, 8'h80);
    tick();
    chk("rst_next_grant", grant, 3'b001);
    drain("rst_drain");

    // Single producer, 9 words: bursts of 4, 4, 1.
    for (int k = 0; k < 9; k++) begin
      src(2, 8'(8'h90 + k));
      expw(2, 8'(8'h90 + k));
    end
    tick();
    chk("single_g1", grant, 3'b100);
    tick(4);
    chk("single_idle1", grant, 0);
    tick();
    chk("single_g2", grant, 3'b100);
    tick(4);
    chk("single_idle2", grant, 0);
    tick();
    chk("single_g3", grant, 3'b100);
    tick();
    chk("single_last_hold", grant, 3'b100);
    tick();
    chk("single_gap_release", grant, 0);
    drain("single_drain");

`ifdef FIFO_WR_ARB_AFULL_EN
    rd_en = 1'b0;
    for (int k = 0; k < 6; k++) begin
      src(0, 8'(8'hF0 + k));
      expw(0, 8'(8'hF0 + k));
    end
    drain("afull_fill");
    chk("afull_usedw", fifo_usedw, 6);
    src(0, 8'hF6);
    expw(0, 8'hF6);
    tick(3);
    chk("afull_hold", grant, 0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    tick();
    chk("afull_grant", grant, 3'b001);
    drain("afull_drain");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
